// File: rtl/gf_mul_v2_if.sv
// ============================================================================
// Module   : gf_mul_v2_if
// Brief    : Operand/result bundle for the GHASH GF(2^128) multiplier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gf_mul_v2_if;
  logic           iNext;
  logic [127:0]   iCtext;
  logic           iCtext_valid;
  logic [0:127]   iHashkey;
  logic           iHashkey_valid;
  logic [0:127]   oResult;
  logic           oResult_valid;

  modport master (
    output iNext, iCtext, iCtext_valid, iHashkey, iHashkey_valid,
    input  oResult, oResult_valid
  );

  modport slave (
    input  iNext, iCtext, iCtext_valid, iHashkey, iHashkey_valid,
    output oResult, oResult_valid
  );
endinterface

`default_nettype wire

// File: rtl/gf_mul_v2.sv
// ============================================================================
// Module   : gf_mul_v2
// Brief    : Iterative GCM-convention GF(2^128) multiplier (X * H) for GHASH.
//            Define GF_MUL_V2_DIGIT8_EN for 8 bits/cycle, else bit-serial.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_mul_v2 (
  input  wire         iClk,
  input  wire         iRstn,
  gf_mul_v2_if.slave  bus
);

`ifdef GF_MUL_V2_DIGIT8_EN
  localparam int DIGIT = 8;
`else
  localparam int DIGIT = 1;
`endif

  localparam logic [6:0]   LAST_STEP = 7'(128 - DIGIT);
  localparam logic [0:127] R_POLY    = {8'hE1, 120'h0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           next_q, next_d;
  logic [127:0]   x_q, x_d;
  logic [0:127]   v_q, v_d;
  logic [0:127]   z_q, z_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [0:127]   result_q, result_d;
  logic           result_valid_q, result_valid_d;
  logic           start_edge;

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q        <= ST_IDLE;
      next_q         <= 1'b0;
      x_q            <= '0;
      v_q            <= '0;
      z_q            <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_q         <= next_d;
      x_q            <= x_d;
      v_q            <= v_d;
      z_q            <= z_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    next_d         = bus.iNext;
    x_d            = x_q;
    v_d            = v_q;
    z_d            = z_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    start_edge     = bus.iNext & ~next_q;

    case (state_q)
      ST_IDLE: begin
        // An edge with an operand invalid is simply dropped; next_q still
        // tracks iNext so the same level cannot retrigger later.
        if (start_edge && bus.iCtext_valid && bus.iHashkey_valid) begin
          state_d = ST_BUSY;
          x_d     = bus.iCtext;
          v_d     = bus.iHashkey;
          z_d     = '0;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        // x_d[127] is the current GCM bit of X; it is shifted out MSB-first.
        for (int k = 0; k < DIGIT; k++) begin
          if (x_d[127]) begin
            z_d = z_d ^ v_d;
          end
          v_d = (v_d >> 1) ^ (v_d[127] ? R_POLY : '0);
          x_d = x_d << 1;
        end
        cnt_d = cnt_q + 7'(DIGIT);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d       = z_q;
        result_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.oResult       = result_q;
  assign bus.oResult_valid = result_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_gf_mul_v2.sv
// ============================================================================
// Module   : tb_gf_mul_v2
// Brief    : Self-checking bench for gf_mul_v2 (honours GF_MUL_V2_DIGIT8_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf_mul_v2;

`ifdef GF_MUL_V2_DIGIT8_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 129;
`endif

  localparam logic [127:0] R_HEX = {8'hE1, 120'h0};

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  gf_mul_v2_if bus ();

  gf_mul_v2 dut (
    .iClk  (clk),
    .iRstn (rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int errors      = 0;
  int pulse_count = 0;
  logic [127:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.oResult_valid === 1'b1) pulse_count++;
  end

  // Reference model in plain hex terms: GCM bit i of X is x[127-i],
  // V[127] of the GCM view is the hex LSB.
  function automatic logic [127:0] gf_model(input logic [127:0] x, input logic [127:0] h);
    logic [127:0] z;
    logic [127:0] v;
    logic         lsb;
    z = '0;
    v = h;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      lsb = v[0];
      v   = v >> 1;
      if (lsb) v = v ^ R_HEX;
    end
    return z;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [127:0] x, input logic [127:0] h);
    bus.iCtext         = x;
    bus.iHashkey       = h;
    bus.iCtext_valid   = 1'b1;
    bus.iHashkey_valid = 1'b1;
    bus.iNext          = 1'b1;
    exp_q.push_back(gf_model(x, h));
    @(posedge clk); #1;
  endtask

  task automatic wait_result(input int hold, input bit glitch, input bit scramble);
    int           n;
    bit           seen;
    logic [127:0] e;
    n    = 0;
    seen = 1'b0;
    if (hold <= 1) bus.iNext = 1'b0;
    if (scramble) begin
      bus.iCtext         = ~bus.iCtext;
      bus.iHashkey       = bus.iHashkey ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      bus.iCtext_valid   = 1'b0;
      bus.iHashkey_valid = 1'b0;
    end
    while (!seen && n < LAT + 20) begin
      @(posedge clk); #1;
      n++;
      if (n == hold - 1) bus.iNext = 1'b0;
      if (glitch && n == 6) bus.iNext = 1'b1;
      if (glitch && n == 7) bus.iNext = 1'b0;
      if (bus.oResult_valid === 1'b1) seen = 1'b1;
    end
    check("pulse_seen", 128'(seen), 128'd1);
    if (seen) begin
      check("latency", 128'(n), 128'(LAT));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("result", bus.oResult, e);
    end
  endtask

  task automatic check_quiet(input int cycles);
    int p;
    @(posedge clk); #1;
    check("pulse_width", 128'(bus.oResult_valid), 128'd0);
    p = pulse_count;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    check("no_extra_pulse", 128'(pulse_count), 128'(p));
  endtask

  logic [127:0] h1, x1, h2, x2, x3, xr, hr, last;
  int           p0;

  initial begin
    bus.iNext          = 1'b0;
    bus.iCtext         = '0;
    bus.iCtext_valid   = 1'b0;
    bus.iHashkey       = '0;
    bus.iHashkey_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", bus.oResult, 128'd0);
    check("reset_valid", 128'(bus.oResult_valid), 128'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Vector 1, iNext held 3 cycles
    h1 = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
    x1 = 128'h0388DACE60B6A392F328C2B971B2FE78;
    start_op(x1, h1);
    wait_result(3, 1'b0, 1'b0);
    check("v1_const", bus.oResult, 128'h5E2EC746917062882C85B0685353DEB7);
    check_quiet(LAT + 5);

    // Vector 2 then chained block started on the first IDLE cycle
    h2 = 128'h73A23D80121DE2D5A850253FCF43120E;
    x2 = 128'hD609B1F056637A0D46DF998D88E52E00;
    start_op(x2, h2);
    wait_result(1, 1'b0, 1'b0);
    check("v2_const", bus.oResult, 128'h9CABBD91899C1413AA7AD629C1DF12CD);
    x3 = 128'h9CABBD91899C1413AA7AD629C1DF12CD ^ 128'hB2C2846512153524C0895E8100000000;
    start_op(x3, h2);
    wait_result(5, 1'b0, 1'b0);
    check("chain_const", bus.oResult, 128'hB99ABF6BDBD18B8E148F8030F0686F28);
    check_quiet(LAT + 5);

    // Identity with a stray iNext edge and operand changes during BUSY
    xr = {$urandom, $urandom, $urandom, $urandom};
    start_op(xr, 128'h80000000000000000000000000000000);
    wait_result(1, 1'b1, 1'b1);
    check("identity", bus.oResult, xr);
    check_quiet(LAT + 5);

    // Zero operand
    start_op(128'd0, h1);
    wait_result(2, 1'b0, 1'b0);
    check("zero", bus.oResult, 128'd0);
    check_quiet(4);

    // Random operands against the model
    xr = {$urandom, $urandom, $urandom, $urandom};
    hr = {$urandom, $urandom, $urandom, $urandom};
    start_op(xr, hr);
    wait_result(1, 1'b0, 1'b0);
    check_quiet(4);
    last = bus.oResult;

    // Gating: edge with H invalid is consumed; raising valid later cannot start
    bus.iCtext         = x1;
    bus.iHashkey       = h1;
    bus.iCtext_valid   = 1'b1;
    bus.iHashkey_valid = 1'b0;
    bus.iNext          = 1'b1;
    p0 = pulse_count;
    @(posedge clk); #1;
    bus.iHashkey_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.iNext = 1'b0;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
    end
    check("gate_no_pulse", 128'(pulse_count), 128'(p0));
    check("gate_hold", bus.oResult, last);

    // Reset mid-BUSY aborts the operation
    start_op(x2, h2);
    bus.iNext = 1'b0;
    repeat (LAT / 2) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst_result", bus.oResult, 128'd0);
    check("rst_valid", 128'(bus.oResult_valid), 128'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    void'(exp_q.pop_back());
    p0 = pulse_count;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
    end
    check("rst_no_pulse", 128'(pulse_count), 128'(p0));
    check("rst_result_hold", bus.oResult, 128'd0);

    // Recovery after reset
    start_op(x1, h1);
    wait_result(1, 1'b0, 1'b0);
    check("recover_const", bus.oResult, 128'h5E2EC746917062882C85B0685353DEB7);
    check_quiet(4);

    check("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gf_mul_v2.md
# gf_mul_v2

Sequential GF(2^128) multiplier for the GHASH stage of the AES-GCM core. On a start request it latches a 128-bit data block X (ciphertext or AAD, already XORed with the running tag by the caller) and the hash subkey H. It then computes X·H in the GCM field iteratively and presents the product with a one-cycle valid pulse. It sits between the AES-CTR datapath and the tag accumulator.

## Interface
- No parameters.
- iClk  in  1  clock; all logic on rising edge.
- iRstn  in  1  reset, synchronous, active-low.
- iNext  in  1  start request; rising level is sampled as an edge.
- iCtext  in  [127:0]  operand X; iCtext[127] is GCM bit 0 (MSB of hex value).
- iCtext_valid  in  1  X is valid.
- iHashkey  in  [0:127]  operand H; iHashkey[0] is GCM bit 0.
- iHashkey_valid  in  1  H is valid.
- oResult  out  [0:127]  product X·H; oResult[0] is GCM bit 0.
- oResult_valid  out  1  one-cycle pulse: oResult holds a new product.

## Operation
- Field: GCM convention, bit 0 = coefficient of x^0 = MSB of hex literal. Polynomial x^128+x^7+x^2+x+1; R = 0xE1 followed by 120 zero bits.
- Per-bit step for i = 0..127, with Z=0 and V=H initially:
  - if X_i = 1 then Z ^= V;
  - if V[127] = 0 then V = V>>1, else V = (V>>1) ^ R.
  - Shifts are toward higher bit index in [0:127] order, i.e. a right shift of the hex value.
- Result = Z after 128 steps.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY on a start edge when iCtext_valid=1 and iHashkey_valid=1. A start edge means iNext=1 this cycle and the registered iNext was 0 last cycle.
  - On the transition, latch X, H, Z=0 and step counter=0.
  - A start edge with either valid low is discarded; the state stays IDLE and the edge is consumed.
- BUSY: perform D steps per cycle; after 128/D cycles go to DONE.
- DONE: load oResult with Z, assert oResult_valid, then return to IDLE.
- iNext edges, operand changes and valid changes while BUSY or DONE are ignored; operands are latched.
- oResult holds its value until the next DONE.

## Timing
- Reset values: oResult = 0, oResult_valid = 0, state IDLE, registered iNext = 0, Z = 0.
  - Consequence: iNext already high on the first cycle after reset counts as a start edge.
- Let edge T be the edge that accepts the start. BUSY covers edges T+1 .. T+128/D.
- oResult and oResult_valid=1 are registered at edge T+128/D+1. oResult_valid returns to 0 at the next edge.
- Latency is 129 cycles when D=1 and 17 cycles when D=8. Both exceed 5 cycles, so an iNext held high for up to 5 cycles never produces a second start.
- Back-to-back: a new start edge is accepted on the first IDLE cycle after DONE.
- Reset asserted mid-operation aborts at the next edge; all registers return to reset values and no valid pulse is issued.
- Reset has priority over start.

## Configuration
- GF_MUL_V2_DIGIT8_EN defined: D = 8. Eight unrolled per-bit steps per cycle, 16 BUSY cycles.
- Macro undefined: D = 1. Bit-serial, 128 BUSY cycles.
- Arithmetic results are identical in both builds; only latency differs.

## Test plan
- Vector 1: H=66E94BD4EF8A2C3B884CFA59CA342B2E, X=0388DACE60B6A392F328C2B971B2FE78, iNext high 3 cycles -> single pulse with oResult=5E2EC746917062882C85B0685353DEB7.
- Vector 2: H=73A23D80121DE2D5A850253FCF43120E, X=D609B1F056637A0D46DF998D88E52E00, iNext high 1 cycle -> oResult=9CABBD91899C1413AA7AD629C1DF12CD.
- Chained: same H, X=9CABBD91899C1413AA7AD629C1DF12CD ^ B2C2846512153524C0895E8100000000, iNext high 5 cycles -> exactly one pulse, oResult=B99ABF6BDBD18B8E148F8030F0686F28.
- Identity and zero:
  - H=80000000000000000000000000000000 (field 1) with any X -> oResult=X.
  - X=0 -> oResult=0.
- Gating: start edge with iHashkey_valid=0 -> no pulse. A second iNext edge during BUSY, or operand changes after the start, -> result matches the originally latched operands.
- Reset: drop iRstn mid-BUSY -> oResult=0, oResult_valid=0, no pulse. A new start after reset completes correctly.
- Latency: check the pulse at exactly T+129 edges (D=1) or T+17 edges (D=8).
